fetch_pc_unit: RTL

//  Program-counter / fetch stage sitting directly upstream of the instruction ROM.

---
 rtl/fetch_pc_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: drives the instruction ROM and selects the next PC.
// It also tracks halt-on-syscall and sticky illegal-PC faults, and counts retired instructions.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0040_0000,
    parameter int unsigned ROM_ADDR_WIDTH  = 8,
    parameter bit          HALT_ON_SYSCALL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic [31:0] rs_value,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        rom_en,
    output logic        instr_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    // 33 bits so a window ending exactly at 2^32 does not wrap to zero.
    localparam logic [32:0] WINDOW_END = {1'b0, RESET_PC} + (33'd4 << ROM_ADDR_WIDTH);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [31:0] count_next;
    logic [31:0] fault_addr_next;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] branch_offset;
    logic        is_jr;
    logic        is_jump;
    logic        is_branch;
    logic        is_syscall;
    logic [31:0] target;
    logic        target_illegal;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    assign is_jr      = (opcode == OP_SPECIAL) && (funct == FN_JR);
    assign is_jump    = (opcode == OP_J) || (opcode == OP_JAL);
    assign is_branch  = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_syscall = HALT_ON_SYSCALL && (opcode == OP_SPECIAL) && (funct == FN_SYSCALL);

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        target = pc_plus4;
        if (is_jr) begin
            target = rs_value;
        end else if (is_jump) begin
            target = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (is_branch && branch_taken) begin
            target = pc_plus4 + branch_offset;
        end
    end

    assign target_illegal = (target[1:0] != 2'b00)
                         || (target < RESET_PC)
                         || ({1'b0, target} >= WINDOW_END);

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        count_next      = retired_count;
        fault_addr_next = fault_addr;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                // Syscall is checked before the fault so a halting syscall never faults.
                if (!stall) begin
                    if (is_syscall) begin
                        state_next = HALT;
                        count_next = retired_count + 32'd1;
                    end else if (target_illegal) begin
                        state_next      = FAULT;
                        fault_addr_next = target;
                    end else begin
                        pc_next    = target;
                        count_next = retired_count + 32'd1;
                    end
                end
            end
            HALT:    state_next = HALT;
            FAULT:   state_next = FAULT;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            retired_count <= '0;
            fault_addr    <= '0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            retired_count <= count_next;
            fault_addr    <= fault_addr_next;
        end
    end

    assign rom_en      = (state == BOOT) || (state == RUN);
    assign instr_valid = (state == RUN);
    assign halted      = (state == HALT);
    assign fault       = (state == FAULT);

endmodule
